longframe_sync_rx: RTL
======================

Name: longframe_sync_rx

Overview:
- Receive-side frame synchroniser for the long-frame strobe.
- Samples an incoming strb that is high for DELAY cycles out of every FRAME_LEN cycles. Checks the pattern, acquires lock, and runs a flywheel slot counter.
- Provides frame_start, slot_cnt and locked to downstream frame-aligned logic.
- Tolerates isolated strobe corruption while locked.

Parameters:
- FRAME_LEN, 256: strobe period in clk cycles; must be ≥ DELAY+2.
- DELAY, 8: expected strobe high width in cycles.
- LOCK_FRAMES, 2: consecutive good frames in CHECK needed to assert locked.
- MISS_FRAMES, 3: consecutive bad frames in LOCKED that drop lock.
- CW, 8: slot counter width, equal to clog2(FRAME_LEN).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- strb  in  1  incoming frame strobe, synchronous to clk.
- frame_start  out  1  one-cycle pulse; the current slot is 0.
- slot_cnt  out  CW  current slot index within the frame, 0..FRAME_LEN-1.
- locked  out  1  high while in LOCKED.
- sync_err  out  1  one-cycle pulse at the end of a bad frame (CHECK or LOCKED).

Behaviour:
- Reset (rst=1 at an edge): state=HUNT. frame_start=0, slot_cnt=0, locked=0, sync_err=0. good/miss counters=0, strb_q=0. rst mid-frame discards all alignment.
- Edge detect: rise = strb & ~strb_q, evaluated on the sample taken at the current edge.
- Slot definition: the sample on which rise is seen is slot 0.
- Output timing: all outputs are registered and describe the sample just taken (one-cycle latency).
  - Example: frame_start=1 and slot_cnt=0 in the cycle after the edge that sampled slot 0.
- Expected pattern per slot s: exp = (s < DELAY). A frame is bad if any sample in slots 0..FRAME_LEN-1 differs from exp. A per-frame mismatch flag accumulates this.
- HUNT:
  - locked=0, frame_start=0, slot_cnt held at 0.
  - On rise: go to CHECK, slot=0, good_cnt=0, mismatch flag cleared.
- CHECK:
  - slot increments every cycle; frame_start pulses at slot 0.
  - First mismatch: sync_err pulse, go to HUNT immediately.
    - If that mismatching sample is itself a rise, go directly to CHECK at slot 0 instead, so an early strobe re-aligns without losing a frame.
  - At slot FRAME_LEN-1 with no mismatch: good_cnt++.
    - If good_cnt reaches LOCK_FRAMES, go to LOCKED. locked=1 in the same cycle as the next frame_start.
    - Otherwise stay in CHECK, slot wraps to 0.
- LOCKED (flywheel):
  - slot wraps FRAME_LEN-1 → 0 unconditionally; frame_start pulses every wrap regardless of strb.
  - A rise at a wrong slot is a mismatch only; there is no re-alignment while locked.
  - At slot FRAME_LEN-1:
    - Bad frame: sync_err pulses, miss_cnt++. When miss_cnt reaches MISS_FRAMES, go to HUNT with locked=0 in the next cycle.
    - Good frame: miss_cnt=0.
- Counters saturate at their limits; no wrap of good_cnt or miss_cnt.
- Simultaneous events at slot FRAME_LEN-1: the end-of-frame decision uses the mismatch flag OR-ed with the current sample's mismatch.
- Strobe stuck high or low: every frame is bad. Lock drops after MISS_FRAMES. HUNT then waits indefinitely for a rise.

Optional Feature:
- Macro: LONGFRAME_SYNC_RX_STATS_EN.
- Defined: adds output err_count (16 bits).
  - Increments on every sync_err pulse and saturates at 0xFFFF.
  - Cleared by rst only.
  - Also adds output lock_count (8 bits), which increments on each HUNT/CHECK→LOCKED transition and saturates.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Shared package longframe_pkg holds:
  - state encoding typedef (HUNT, CHECK, LOCKED);
  - default constants LF_FRAME_LEN=256 and LF_DELAY=8, shared with the strobe generator.
- One natural sub-module: longframe_slot_ctr.
  - Loadable modulo-FRAME_LEN counter with a wrap output.
  - Inputs: clear-to-zero and enable.

Test Plan:
- Ideal strobe (DELAY=8, period 256, first rise sampled 10 cycles after rst release) → frame_start every 256 cycles from the first rise. locked=1 coincident with the 3rd frame_start. sync_err never asserts.
- Once locked, one frame with strb width 7 → one sync_err at that frame's slot 255. locked stays 1 and frame_start keeps period 256. The next good frame clears miss_cnt.
- Once locked, strb held low for 3 frames → 3 sync_err pulses. locked falls in the cycle after the 3rd frame's slot 255. The state is HUNT.
- In CHECK, the next rise arrives 200 cycles after the first → sync_err pulse. Re-alignment to slot 0 at that rise, good_cnt=0. Lock follows after 2 further good frames.
- rst asserted at slot 100 while locked → next cycle: outputs 0, state HUNT. After release, lock is re-acquired from the next rise.
- With LONGFRAME_SYNC_RX_STATS_EN, run scenarios 2 and 3 back to back → err_count=4, lock_count=1.

Source files
------------

// File: rtl/longframe_pkg.sv
// Shared definitions for the long-frame strobe generator and receiver.
package longframe_pkg;
  localparam int LF_FRAME_LEN = 256;
  localparam int LF_DELAY     = 8;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } lf_state_e;
endpackage

// File: rtl/longframe_slot_ctr.sv
// Modulo-FRAME_LEN slot counter with synchronous clear, enable, wrap flag and look-ahead value.
import longframe_pkg::*;

module longframe_slot_ctr #(
  parameter int FRAME_LEN = LF_FRAME_LEN,
  parameter int CW        = $clog2(FRAME_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] nxt_o,
  output logic          wrap_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == CW'(FRAME_LEN - 1));
  assign nxt_o  = wrap_o ? '0 : cnt_q + 1'b1;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = nxt_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/longframe_sync_rx.sv
// Long-frame strobe synchroniser: hunt for a rise, verify LOCK_FRAMES frames, then flywheel.
// Define LONGFRAME_SYNC_RX_STATS_EN to add the err_count and lock_count statistics outputs.
import longframe_pkg::*;

module longframe_sync_rx #(
  parameter int FRAME_LEN   = LF_FRAME_LEN,
  parameter int DELAY       = LF_DELAY,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_FRAMES = 3,
  parameter int CW          = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strb,
  output logic          frame_start,
  output logic [CW-1:0] slot_cnt,
  output logic          locked,
  output logic          sync_err
`ifdef LONGFRAME_SYNC_RX_STATS_EN
  ,
  output logic [15:0]   err_count,
  output logic [7:0]    lock_count
`endif
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int MW = $clog2(MISS_FRAMES + 1);

  lf_state_e     state_q, state_d;
  logic          strb_q;
  logic          fs_q, fs_d;
  logic          err_q, err_d;
  logic          locked_q;
  logic          mis_q, mis_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          clr, en, rise, mm, eof;
  logic [CW-1:0] nxt;
  logic          wrap;

  longframe_slot_ctr #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_slot (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (clr),
    .en_i   (en),
    .cnt_o  (slot_cnt),
    .nxt_o  (nxt),
    .wrap_o (wrap)
  );

  // nxt is the slot of the sample being taken at this edge when the counter advances.
  assign rise = strb & ~strb_q;
  assign mm   = (strb != (nxt < CW'(DELAY)));
  assign eof  = (nxt == CW'(FRAME_LEN - 1));

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    fs_d    = 1'b0;
    err_d   = 1'b0;
    mis_d   = mis_q;
    good_d  = good_q;
    miss_d  = miss_q;
    unique case (state_q)
      HUNT: begin
        clr = 1'b1;
        if (rise) begin
          state_d = CHECK;
          fs_d    = 1'b1;
          good_d  = '0;
          mis_d   = 1'b0;
        end
      end
      CHECK: begin
        if (mm) begin
          // An early rise re-aligns straight into a fresh frame instead of hunting again.
          err_d  = 1'b1;
          clr    = 1'b1;
          good_d = '0;
          mis_d  = 1'b0;
          if (rise) fs_d = 1'b1;
          else      state_d = HUNT;
        end else begin
          en   = 1'b1;
          fs_d = wrap;
          if (eof) begin
            if (int'(good_q) < LOCK_FRAMES) good_d = good_q + 1'b1;
            if (int'(good_q) + 1 >= LOCK_FRAMES) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end
        end
      end
      LOCKED: begin
        en    = 1'b1;
        fs_d  = wrap;
        mis_d = wrap ? mm : (mis_q | mm);
        if (eof) begin
          if (mis_q | mm) begin
            err_d = 1'b1;
            if (int'(miss_q) < MISS_FRAMES) miss_d = miss_q + 1'b1;
            if (int'(miss_q) + 1 >= MISS_FRAMES) state_d = HUNT;
          end else begin
            miss_d = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // locked follows the state one sample late so it rises with the first flywheel frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      strb_q   <= 1'b0;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      mis_q    <= 1'b0;
      good_q   <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb;
      fs_q     <= fs_d;
      err_q    <= err_d;
      locked_q <= (state_q == LOCKED);
      mis_q    <= mis_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
    end
  end

  assign frame_start = fs_q;
  assign sync_err    = err_q;
  assign locked      = locked_q;

`ifdef LONGFRAME_SYNC_RX_STATS_EN
  logic [15:0] err_cnt_q;
  logic [7:0]  lock_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
      if ((state_q != LOCKED) && (state_d == LOCKED) && (lock_cnt_q != 8'hFF))
        lock_cnt_q <= lock_cnt_q + 1'b1;
    end
  end

  assign err_count  = err_cnt_q;
  assign lock_count = lock_cnt_q;
`endif
endmodule
